// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the pulse_gen burst generator.
package pulse_gen_pkg;

    localparam int PG_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2,
        ST_FINISH = 2'd3
    } pg_state_e;

endpackage

// File: rtl/pulse_gen_timer.sv
// Loadable half-period down-counter; expired is high while the count sits at zero.
module pulse_gen_timer
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != ZERO) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == ZERO);

endmodule

// File: rtl/pulse_gen.sv
// Burst square-wave generator. Optional abort input enabled by macro PULSE_GEN_ABORT_EN.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PULSE_GEN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [CNT_W-1:0] half_period,
    input  logic [CNT_W-1:0] num_pulses,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    pg_state_e        state_r;
    pg_state_e        next_s;
    logic [CNT_W-1:0] hp_r;
    logic [CNT_W-1:0] np_r;
    logic [CNT_W-1:0] sent_r;
    logic             pulse_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             expired_s;
    logic             abort_s;
    logic             accept_s;

    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] hp);
        if (hp == ZERO) begin
            eff_half = ONE;
        end else begin
            eff_half = hp;
        end
    endfunction

`ifdef PULSE_GEN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s = (state_r == ST_IDLE) && start;

    pulse_gen_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Next-state logic and timer reload on every phase entry.
    always_comb begin
        next_s     = state_r;
        load_s     = 1'b0;
        load_val_s = hp_r - ONE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_pulses == ZERO) begin
                        next_s = ST_FINISH;
                    end else begin
                        next_s     = ST_HIGH;
                        load_s     = 1'b1;
                        load_val_s = eff_half(half_period) - ONE;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (abort_s) begin
                    next_s = ST_FINISH;
                end else if (expired_s) begin
                    next_s = ST_LOW;
                    load_s = 1'b1;
                end else begin
                    next_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (abort_s) begin
                    next_s = ST_FINISH;
                end else if (expired_s) begin
                    if (sent_r < np_r) begin
                        next_s = ST_HIGH;
                        load_s = 1'b1;
                    end else begin
                        next_s = ST_FINISH;
                    end
                end else begin
                    next_s = ST_LOW;
                end
            end
            ST_FINISH: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            pulse_r <= (next_s == ST_HIGH);
            busy_r  <= (next_s != ST_IDLE);
            done_r  <= (next_s == ST_FINISH);
        end
    end

    // Latched burst configuration and rising-edge count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hp_r   <= ZERO;
            np_r   <= ZERO;
            sent_r <= ZERO;
        end else if (accept_s) begin
            hp_r   <= eff_half(half_period);
            np_r   <= num_pulses;
            sent_r <= (num_pulses == ZERO) ? ZERO : ONE;
        end else if ((state_r == ST_LOW) && (next_s == ST_HIGH) && (sent_r < np_r)) begin
            hp_r   <= hp_r;
            np_r   <= np_r;
            sent_r <= sent_r + ONE;
        end else begin
            hp_r   <= hp_r;
            np_r   <= np_r;
            sent_r <= sent_r;
        end
    end

    assign pulse = pulse_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign sent  = sent_r;

endmodule
